// File: rtl/sm4_mode_ctrl.sv
// SM4 mode-of-operation controller: ECB/CBC/CTR chaining around an
// external SM4 core, one block in flight, with an output FIFO.
module sm4_mode_ctrl #(
    parameter int OUT_FIFO_DEPTH = 4,
    parameter int CTR_W          = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start_in,
    input  logic [1:0]   mode_in,
    input  logic         encdec_sel_in,
    input  logic [127:0] iv_in,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_data,
    input  logic         in_last,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_data,
    output logic         out_last,
    output logic         core_valid_out,
    output logic         core_encdec_sel_out,
    output logic [127:0] core_data_out,
    input  logic         core_ready_in,
    input  logic [127:0] core_result_in,
    output logic         busy_out,
    output logic         err_out
);

    localparam int AW = (OUT_FIFO_DEPTH > 1) ? $clog2(OUT_FIFO_DEPTH) : 1;
    localparam int CW = AW + 1;

    localparam logic [1:0] M_CBC = 2'b01;
    localparam logic [1:0] M_CTR = 2'b10;
    localparam logic [1:0] M_RSV = 2'b11;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        ISSUE,
        WAIT,
        POST
    } state_t;

    state_t         state;
    state_t         state_nx;
    logic [1:0]     mode;
    logic           sel;
    logic [127:0]   chain;
    logic [127:0]   blk;
    logic [127:0]   res;
    logic           last;
    logic [127:0]   post_data;
    logic           in_fire;
    logic           out_fire;
    logic           push;

    logic [127:0]   fifo_data [OUT_FIFO_DEPTH];
    logic           fifo_last [OUT_FIFO_DEPTH];
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;
    logic [CW-1:0]  count;

    // a slot is held back in LOAD so the later POST push always fits
    assign in_ready       = (state == LOAD) && (count < CW'(OUT_FIFO_DEPTH));
    assign in_fire        = in_valid && in_ready;
    assign push           = (state == POST);
    assign out_valid      = (count != '0);
    assign out_fire       = out_valid && out_ready;
    assign out_data       = out_valid ? fifo_data[rd_ptr] : '0;
    assign out_last       = out_valid ? fifo_last[rd_ptr] : 1'b0;
    assign core_valid_out = (state == ISSUE);
    assign busy_out       = (state != IDLE) || out_valid;

    // state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    // next-state decode
    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (start_in && mode_in != M_RSV) state_nx = LOAD;
            LOAD:    if (in_fire) state_nx = ISSUE;
            ISSUE:   state_nx = WAIT;
            WAIT:    if (core_ready_in) state_nx = POST;
            POST:    state_nx = last ? IDLE : LOAD;
            default: state_nx = IDLE;
        endcase
    end

    // result block as written to the FIFO for the active mode
    always_comb begin
        post_data = res;
        if (mode == M_CBC && sel) post_data = res ^ chain;
        else if (mode == M_CTR)   post_data = blk ^ res;
    end

    // message context, block registers, core request and error flag
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mode                <= '0;
            sel                 <= 1'b0;
            chain               <= '0;
            blk                 <= '0;
            res                 <= '0;
            last                <= 1'b0;
            core_data_out       <= '0;
            core_encdec_sel_out <= 1'b0;
            err_out             <= 1'b0;
        end else begin
            if (start_in) begin
                if (state != IDLE || mode_in == M_RSV) begin
                    err_out <= 1'b1;
                end else begin
                    err_out <= 1'b0;
                    mode    <= mode_in;
                    sel     <= encdec_sel_in;
                    chain   <= iv_in;
                end
            end
            if (in_fire) begin
                blk  <= in_data;
                last <= in_last;
                unique case (mode)
                    M_CBC:   core_data_out <= sel ? in_data : in_data ^ chain;
                    M_CTR:   core_data_out <= chain;
                    default: core_data_out <= in_data;
                endcase
                core_encdec_sel_out <= (mode == M_CTR) ? 1'b0 : sel;
            end
            if (state == WAIT && core_ready_in) res <= core_result_in;
            if (push) begin
                if (mode == M_CBC) chain <= sel ? blk : res;
                else if (mode == M_CTR)
                    chain[CTR_W-1:0] <= chain[CTR_W-1:0] + CTR_W'(1);
            end
        end
    end

    // FIFO storage, contents only meaningful below count
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_data[wr_ptr] <= post_data;
            fifo_last[wr_ptr] <= last;
        end
    end

    // FIFO pointers and occupancy
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)     wr_ptr <= wr_ptr + AW'(1);
            if (out_fire) rd_ptr <= rd_ptr + AW'(1);
            unique case ({push, out_fire})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_sm4_mode_ctrl.sv
// Bench for sm4_mode_ctrl: stand-in SM4 core, mode reference model
// and output scoreboard driven by directed steps.
module tb_sm4_mode_ctrl;

    localparam int L = 3;
    localparam logic [127:0] PT = 128'h0123456789abcdeffedcba9876543210;
    localparam logic [127:0] CT = 128'h681edf34d206965e86b3e94f536e4246;
    localparam logic [127:0] TK = 128'h3c6ef372a54ff53a510e527f9b05688c;

    typedef struct packed { logic last; logic [127:0] d; } blk_t;
    typedef struct packed { logic sel; logic [127:0] d; } creq_t;

    logic         clk = 1'b0;
    logic         reset;
    logic         start_in;
    logic [1:0]   mode_in;
    logic         encdec_sel_in;
    logic [127:0] iv_in;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] in_data;
    logic         in_last;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_data;
    logic         out_last;
    logic         core_valid_out;
    logic         core_encdec_sel_out;
    logic [127:0] core_data_out;
    logic         core_ready_in = 1'b0;
    logic [127:0] core_result_in = '0;
    logic         busy_out;
    logic         err_out;

    int total = 0;
    int bad = 0;

    blk_t   stim[$];
    blk_t   sb[$];
    creq_t  cq[$];
    logic [127:0] outs[$];

    logic [1:0]   m_mode;
    logic         m_sel;
    logic [127:0] m_chain;

    bit  or_en = 1'b1;
    bit  inj_arm = 1'b0;
    bit  core_en = 1'b1;
    bit  poke = 1'b0;
    int  nacc, ncore;
    int  t_hs, t_cv, t_cr, t_ov;
    logic [127:0] last_core;
    logic         last_sel;
    int           core_cnt = 0;
    logic [127:0] core_q = '0;

    sm4_mode_ctrl #(.OUT_FIFO_DEPTH(4), .CTR_W(32)) dut (
        .clk(clk),
        .reset(reset),
        .start_in(start_in),
        .mode_in(mode_in),
        .encdec_sel_in(encdec_sel_in),
        .iv_in(iv_in),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_data(in_data),
        .in_last(in_last),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data(out_data),
        .out_last(out_last),
        .core_valid_out(core_valid_out),
        .core_encdec_sel_out(core_encdec_sel_out),
        .core_data_out(core_data_out),
        .core_ready_in(core_ready_in),
        .core_result_in(core_result_in),
        .busy_out(busy_out),
        .err_out(err_out)
    );

    always #5 clk = ~clk;

    // Stand-in core: the published SM4 reference pair is hard-wired,
    // every other block goes through an invertible toy permutation.
    function automatic logic [127:0] core_fn(input logic [127:0] x,
                                             input logic dec);
        logic [127:0] y;
        if (!dec && x == PT) return CT;
        if (dec && x == CT) return PT;
        if (!dec) return {x[114:0], x[127:115]} ^ TK;
        y = x ^ TK;
        return {y[12:0], y[127:13]};
    endfunction

    always @(posedge clk) begin
        core_ready_in <= 1'b0;
        if (core_cnt > 0) begin
            core_cnt <= core_cnt - 1;
            if (core_cnt == 1) begin
                core_ready_in  <= 1'b1;
                core_result_in <= core_q;
            end
        end
        if (core_valid_out && core_en) begin
            core_cnt <= L;
            core_q   <= core_fn(core_data_out, core_encdec_sel_out);
        end
        if (poke) begin
            core_ready_in  <= 1'b1;
            core_result_in <= ~core_q;
        end
    end

    task automatic chk(input string tag, input logic [127:0] obs,
                       input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_rst(input string p);
        chk({p, "_in_ready"}, 128'(in_ready), 128'd0);
        chk({p, "_out_valid"}, 128'(out_valid), 128'd0);
        chk({p, "_out_data"}, out_data, 128'd0);
        chk({p, "_out_last"}, 128'(out_last), 128'd0);
        chk({p, "_core_valid"}, 128'(core_valid_out), 128'd0);
        chk({p, "_core_sel"}, 128'(core_encdec_sel_out), 128'd0);
        chk({p, "_core_data"}, core_data_out, 128'd0);
        chk({p, "_busy"}, 128'(busy_out), 128'd0);
        chk({p, "_err"}, 128'(err_out), 128'd0);
    endtask

    // reference model: expected core request and output for one block
    task automatic model_accept(input blk_t b);
        logic [127:0] ci, r, o;
        logic s;
        s = m_sel;
        case (m_mode)
            2'b01: begin
                ci = s ? b.d : b.d ^ m_chain;
                r  = core_fn(ci, s);
                o  = s ? r ^ m_chain : r;
                m_chain = s ? b.d : r;
            end
            2'b10: begin
                s  = 1'b0;
                ci = m_chain;
                r  = core_fn(ci, 1'b0);
                o  = b.d ^ r;
                m_chain[31:0] = m_chain[31:0] + 32'd1;
            end
            default: begin
                ci = b.d;
                r  = core_fn(ci, s);
                o  = r;
            end
        endcase
        cq.push_back({s, ci});
        sb.push_back({b.last, o});
    endtask

    task automatic start_msg(input logic [1:0] m, input logic s,
                             input logic [127:0] iv);
        start_in = 1'b1;
        mode_in = m;
        encdec_sel_in = s;
        iv_in = iv;
        @(negedge clk);
        start_in = 1'b0;
        if (m != 2'b11) begin
            m_mode = m;
            m_sel = s;
            m_chain = iv;
        end
    endtask

    task automatic run(input int max_cyc, input bit must_drain);
        int cyc;
        int inj;
        blk_t e;
        creq_t c;
        cyc = 0;
        inj = 0;
        t_hs = -1; t_cv = -1; t_cr = -1; t_ov = -1;
        while ((stim.size() > 0 || sb.size() > 0) && cyc < max_cyc) begin
            start_in = 1'b0;
            if (inj == 1) begin
                start_in = 1'b1;
                mode_in = 2'b00;
                encdec_sel_in = 1'b1;
                iv_in = 128'h5a5a5a5a_a5a5a5a5_5a5a5a5a_a5a5a5a5;
                inj = 2;
                inj_arm = 1'b0;
            end
            in_valid = (stim.size() > 0);
            if (in_valid) {in_last, in_data} = stim[0];
            out_ready = or_en;
            if (core_ready_in && t_cr < 0) t_cr = cyc;
            if (out_valid && t_ov < 0 && t_hs >= 0) t_ov = cyc;
            if (core_valid_out) begin
                ncore++;
                last_core = core_data_out;
                last_sel = core_encdec_sel_out;
                if (t_cv < 0) t_cv = cyc;
                chk("core_one_pending", 128'(cq.size()), 128'd1);
                if (cq.size() > 0) begin
                    c = cq.pop_front();
                    chk("core_data", core_data_out, c.d);
                    chk("core_sel", 128'(core_encdec_sel_out), 128'(c.sel));
                end
                if (inj_arm && inj == 0) inj = 1;
            end
            if (out_valid && out_ready) begin
                chk("out_expected", 128'(sb.size() > 0), 128'd1);
                if (sb.size() > 0) begin
                    e = sb.pop_front();
                    outs.push_back(out_data);
                    chk("out_data", out_data, e.d);
                    chk("out_last", 128'(out_last), 128'(e.last));
                end
            end
            if (in_valid && in_ready) begin
                t_hs = cyc;
                nacc++;
                model_accept(stim.pop_front());
            end
            @(posedge clk);
            @(negedge clk);
            cyc++;
        end
        in_valid = 1'b0;
        out_ready = 1'b0;
        start_in = 1'b0;
        if (must_drain)
            chk("drain_timeout", 128'(stim.size() + sb.size()), 128'd0);
    endtask

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    initial begin
        logic [127:0] p1, p2, iv;
        reset = 1'b1;
        start_in = 1'b0;
        mode_in = 2'b00;
        encdec_sel_in = 1'b0;
        iv_in = '0;
        in_valid = 1'b0;
        in_data = '0;
        in_last = 1'b0;
        out_ready = 1'b0;
        repeat (2) @(negedge clk);
        check_rst("reset");
        reset = 1'b0;
        @(negedge clk);

        // ECB known answer, latency and busy release
        start_msg(2'b00, 1'b0, '0);
        outs.delete();
        stim.push_back({1'b1, PT});
        run(60, 1'b1);
        chk("ecb_kat", outs[0], CT);
        chk("ecb_busy_after_pop", 128'(busy_out), 128'd0);
        chk("lat_issue", 128'(t_cv - t_hs), 128'd1);
        chk("lat_out", 128'(t_ov - t_hs), 128'((t_cr - t_cv) + 3));

        // CBC encrypt then decrypt, zero IV
        start_msg(2'b01, 1'b0, '0);
        outs.delete();
        stim.push_back({1'b1, PT});
        run(60, 1'b1);
        chk("cbc_enc_kat", outs[0], CT);
        start_msg(2'b01, 1'b1, '0);
        outs.delete();
        stim.push_back({1'b1, CT});
        run(60, 1'b1);
        chk("cbc_dec_kat", outs[0], PT);

        // reserved mode
        start_msg(2'b11, 1'b0, '0);
        chk("rsv_err", 128'(err_out), 128'd1);
        chk("rsv_in_ready", 128'(in_ready), 128'd0);
        chk("rsv_busy", 128'(busy_out), 128'd0);

        // two-block CBC round trip, stray start during WAIT
        iv = rnd128();
        p1 = rnd128();
        p2 = rnd128();
        start_msg(2'b01, 1'b0, iv);
        chk("start_clears_err", 128'(err_out), 128'd0);
        outs.delete();
        stim.push_back({1'b0, p1});
        stim.push_back({1'b1, p2});
        inj_arm = 1'b1;
        run(100, 1'b1);
        chk("wait_start_err", 128'(err_out), 128'd1);
        start_msg(2'b01, 1'b1, iv);
        stim.push_back({1'b0, outs[0]});
        stim.push_back({1'b1, outs[1]});
        outs.delete();
        run(100, 1'b1);
        chk("cbc_rt_p1", outs[0], p1);
        chk("cbc_rt_p2", outs[1], p2);

        // CTR counter wrap, direction forced to encrypt
        iv = 128'hfedcba98_76543210_0badf00d_ffffffff;
        start_msg(2'b10, 1'b1, iv);
        stim.push_back({1'b0, rnd128()});
        stim.push_back({1'b1, rnd128()});
        run(100, 1'b1);
        chk("ctr_low_wrap", 128'(last_core[31:0]), 128'd0);
        chk("ctr_upper", 128'(last_core[127:32]), 128'(iv[127:32]));
        chk("ctr_sel", 128'(last_sel), 128'd0);

        // backpressure: six blocks into a four-entry FIFO
        start_msg(2'b00, 1'b0, '0);
        for (int i = 0; i < 6; i++) stim.push_back({(i == 5), rnd128()});
        nacc = 0;
        ncore = 0;
        or_en = 1'b0;
        run(80, 1'b0);
        chk("bp_accepted", 128'(nacc), 128'd4);
        chk("bp_left", 128'(stim.size()), 128'd2);
        chk("bp_in_ready", 128'(in_ready), 128'd0);
        chk("bp_out_valid", 128'(out_valid), 128'd1);
        or_en = 1'b1;
        run(300, 1'b1);
        chk("bp_total", 128'(nacc), 128'd6);
        chk("bp_core_pulses", 128'(ncore), 128'd6);
        chk("bp_busy", 128'(busy_out), 128'd0);

        // reset while waiting on the core, late result ignored
        core_en = 1'b0;
        start_msg(2'b00, 1'b0, '0);
        stim.push_back({1'b1, PT});
        run(12, 1'b0);
        chk("rw_busy_before", 128'(busy_out), 128'd1);
        reset = 1'b1;
        @(negedge clk);
        check_rst("mid_reset");
        reset = 1'b0;
        poke = 1'b1;
        @(negedge clk);
        poke = 1'b0;
        repeat (4) @(negedge clk);
        check_rst("after_poke");
        sb.delete();
        cq.delete();
        core_en = 1'b1;
        start_msg(2'b00, 1'b0, '0);
        outs.delete();
        stim.push_back({1'b1, PT});
        run(60, 1'b1);
        chk("post_reset_ecb", outs[0], CT);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
